sr_btn_conditioner: RTL and testbench

//  Upstream stage of the SR flip-flop. Takes two raw asynchronous pushbutton

---
 rtl/sr_btn_conditioner.sv | 138 +++++++++++++
 tb/tb_sr_btn_conditioner.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sr_btn_conditioner.sv
// Button front end for the SR flip-flop: synchronises, debounces and edge-detects
// the raw set/clear buttons and issues spaced, mutually exclusive one-cycle s/r pulses.
module sr_btn_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5,
    parameter int GAP_CYCLES      = 4,
    parameter bit CLR_PRIORITY    = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic set_btn,
    input  logic clr_btn,
    output logic s,
    output logic r,
    output logic set_lvl,
    output logic clr_lvl,
    output logic conflict
);

    localparam int GAP_W  = (GAP_CYCLES < 3) ? 2 : $clog2(GAP_CYCLES + 1);
    localparam int WARM_W = $clog2(SYNC_STAGES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [WARM_W-1:0] WARM_FULL = WARM_W'(SYNC_STAGES);

    typedef enum logic [1:0] {IDLE, EMIT, GAP} state_t;

    // Channel index 0 is set, index 1 is clear throughout.
    logic [SYNC_STAGES-1:0] sync_set;
    logic [SYNC_STAGES-1:0] sync_clr;
    logic [1:0]             synced;
    logic [1:0]             lvl;
    logic [1:0]             lvl_d;
    logic [1:0]             armed;
    logic [1:0]             rise_q;
    logic [1:0]             pending;
    logic [CNT_W-1:0]       cnt [2];
    logic [WARM_W-1:0]      warm;
    logic                   warm_done;
    logic [GAP_W-1:0]       gap_cnt;
    logic                   clr_win;
    state_t                 state;

    assign synced    = {sync_clr[SYNC_STAGES-1], sync_set[SYNC_STAGES-1]};
    assign warm_done = (warm == WARM_FULL);
    assign clr_win   = pending[1] & (~pending[0] | CLR_PRIORITY);
    assign set_lvl   = lvl[0];
    assign clr_lvl   = lvl[1];

    // NOTE: every register below uses <= so all flops sample pre-edge values,
    // which keeps the pipeline stage counts exact regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_set <= '0;
            sync_clr <= '0;
        end else begin
            sync_set <= {sync_set[SYNC_STAGES-2:0], set_btn};
            sync_clr <= {sync_clr[SYNC_STAGES-2:0], clr_btn};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvl <= '0;
            for (int ch = 0; ch < 2; ch++) cnt[ch] <= '0;
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                if (synced[ch] == lvl[ch]) begin
                    cnt[ch] <= '0;
                end else if (cnt[ch] == CNT_LAST) begin
                    lvl[ch] <= ~lvl[ch];
                    cnt[ch] <= '0;
                end else begin
                    cnt[ch] <= cnt[ch] + CNT_W'(1);
                end
            end
        end
    end

    // A button still held through reset must be seen released before it can
    // issue a command, so re-debouncing after reset never replays a stale press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            warm   <= '0;
            armed  <= '0;
            lvl_d  <= '0;
            rise_q <= '0;
        end else begin
            if (!warm_done) warm <= warm + WARM_W'(1);
            armed  <= armed | ({2{warm_done}} & ~synced & ~lvl);
            lvl_d  <= lvl;
            rise_q <= lvl & ~lvl_d & armed;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pending  <= '0;
            gap_cnt  <= '0;
            s        <= 1'b0;
            r        <= 1'b0;
            conflict <= 1'b0;
        end else begin
            s        <= 1'b0;
            r        <= 1'b0;
            conflict <= 1'b0;
            pending  <= pending | rise_q;
            case (state)
                IDLE: begin
                    if (|pending) begin
                        // Winner and loser are both consumed; only fresh edges survive.
                        pending  <= rise_q;
                        s        <= ~clr_win;
                        r        <= clr_win;
                        conflict <= &pending;
                        state    <= EMIT;
                    end
                end
                EMIT: begin
                    if (GAP_CYCLES == 1) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= GAP_W'(GAP_CYCLES);
                        state   <= GAP;
                    end
                end
                GAP: begin
                    // The following IDLE cycle is itself the last quiet cycle.
                    if (gap_cnt <= GAP_W'(2)) state <= IDLE;
                    else gap_cnt <= gap_cnt - GAP_W'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sr_btn_conditioner.sv
// Self-checking bench: a timestamp/run-length model of the conditioner is compared
// against the DUT every cycle, plus directed scenarios with hand-computed expectations.
module tb_sr_btn_conditioner;

    localparam int SYNC    = 2;
    localparam int DEB     = 4;
    localparam int GAP     = 2;
    localparam bit CLR_PRI = 1'b1;

    logic clk = 1'b0;
    logic rst;
    logic set_btn = 1'b0;
    logic clr_btn = 1'b0;
    logic s, r, set_lvl, clr_lvl, conflict;

    int errors = 0;
    int checks = 0;

    sr_btn_conditioner #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (5),
        .GAP_CYCLES     (GAP),
        .CLR_PRIORITY   (CLR_PRI)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .set_btn (set_btn),
        .clr_btn (clr_btn),
        .s       (s),
        .r       (r),
        .set_lvl (set_lvl),
        .clr_lvl (clr_lvl),
        .conflict(conflict)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Raw samples are delayed SYNC edges; a level flips after DEB consecutive
    // disagreeing samples; a new level-high becomes a request two edges later;
    // a request is served at the first edge at least GAP+1 after the last pulse.
    logic [1:0] raw_q[$];
    int         edge_n    = 0;
    int         last_emit = -1000;
    int         m_run[2]  = '{0, 0};
    logic [1:0] m_lvl     = '0;
    logic [1:0] m_armed   = '0;
    logic [1:0] m_rose    = '0;
    logic [1:0] m_rq      = '0;
    logic [1:0] m_pend    = '0;
    logic       m_s       = 1'b0;
    logic       m_r       = 1'b0;
    logic       m_conf    = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            raw_q.delete();
            edge_n    = 0;
            last_emit = -1000;
            m_run     = '{0, 0};
            m_lvl     = '0;
            m_armed   = '0;
            m_rose    = '0;
            m_rq      = '0;
            m_pend    = '0;
            m_s       = 1'b0;
            m_r       = 1'b0;
            m_conf    = 1'b0;
        end else begin : step
            logic [1:0] syn;
            logic [1:0] take;
            logic [1:0] nxt_pend;
            logic [1:0] nxt_rose;
            logic       cw;
            edge_n++;
            syn = (raw_q.size() == SYNC) ? raw_q[0] : 2'b00;
            if (raw_q.size() == SYNC) void'(raw_q.pop_front());
            raw_q.push_back({clr_btn, set_btn});

            take   = 2'b00;
            m_s    = 1'b0;
            m_r    = 1'b0;
            m_conf = 1'b0;
            if (m_pend != 2'b00 && edge_n >= last_emit + GAP + 1) begin
                cw        = m_pend[1] && (!m_pend[0] || CLR_PRI);
                m_r       = cw;
                m_s       = !cw;
                m_conf    = m_pend[0] && m_pend[1];
                last_emit = edge_n;
                take      = 2'b11;
            end
            nxt_pend = m_rq | (m_pend & ~take);
            m_rq     = m_rose & m_armed;
            nxt_rose = 2'b00;
            for (int ch = 0; ch < 2; ch++) begin
                if (edge_n > SYNC && !syn[ch] && !m_lvl[ch]) m_armed[ch] = 1'b1;
                if (syn[ch] != m_lvl[ch]) begin
                    m_run[ch]++;
                    if (m_run[ch] == DEB) begin
                        m_lvl[ch]    = ~m_lvl[ch];
                        m_run[ch]    = 0;
                        nxt_rose[ch] = m_lvl[ch];
                    end
                end else begin
                    m_run[ch] = 0;
                end
            end
            m_rose = nxt_rose;
            m_pend = nxt_pend;
        end
    end

    // One compare process, every cycle, sampled on the falling edge.
    always @(negedge clk) begin
        check("cmp_s", s, m_s);
        check("cmp_r", r, m_r);
        check("cmp_set_lvl", set_lvl, m_lvl[0]);
        check("cmp_clr_lvl", clr_lvl, m_lvl[1]);
        check("cmp_conflict", conflict, m_conf);
        check("inv_s_and_r", s & r, 1'b0);
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic sb, input logic cb);
        @(negedge clk);
        #1;
        set_btn = sb;
        clr_btn = cb;
    endtask

    task automatic wait_pulse(input string name, input bit want_r, input int budget, output int n);
        n = 0;
        while (((want_r ? r : s) !== 1'b1) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, ((want_r ? r : s) === 1'b1), 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // 1: reset, then quiet buttons
        rst = 1'b1;
        cyc(3);
        #1 rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("t1_idle_outputs", {s, r, set_lvl, clr_lvl, conflict}, 5'b0);
        end

        // 2: clean set press, latency SYNC+DEB+2 = 8 edges after first sample
        drive(1'b1, 1'b0);
        wait_pulse("t2_s_seen", 1'b0, 30, n);
        check("t2_latency", n - 1, 8);
        check("t2_r_low", r, 1'b0);
        check("t2_set_lvl", set_lvl, 1'b1);
        @(negedge clk);
        check("t2_s_one_cycle", s, 1'b0);
        drive(1'b0, 1'b0);
        cyc(15);

        // 3: one-cycle glitches are rejected
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check("t3_glitch_lvl", set_lvl, 1'b0);
            check("t3_glitch_s", s, 1'b0);
        end

        // 4: simultaneous press, clear wins with conflict, set is dropped
        drive(1'b1, 1'b1);
        wait_pulse("t4_r_seen", 1'b1, 30, n);
        check("t4_latency", n - 1, 8);
        check("t4_conflict", conflict, 1'b1);
        check("t4_s_low", s, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("t4_no_late_s", s, 1'b0);
        end
        drive(1'b0, 1'b0);
        cyc(15);

        // 5: clear then set two cycles later; s follows r after GAP+1 cycles
        drive(1'b0, 1'b1);
        cyc(1);
        drive(1'b1, 1'b1);
        wait_pulse("t5_r_seen", 1'b1, 30, n);
        check("t5_no_conflict", conflict, 1'b0);
        wait_pulse("t5_s_seen", 1'b0, 30, n);
        check("t5_gap", n, GAP + 1);
        check("t5_r_low", r, 1'b0);
        drive(1'b0, 1'b0);
        cyc(15);

        // 6: asynchronous reset during EMIT, no stale pulse after release
        drive(1'b1, 1'b0);
        wait_pulse("t6_s_seen", 1'b0, 30, n);
        #1 rst = 1'b1;
        #1;
        check("t6_async_s", s, 1'b0);
        check("t6_async_lvl", set_lvl, 1'b0);
        cyc(2);
        #1 rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            check("t6_no_stale_s", s, 1'b0);
        end
        check("t6_relevel", set_lvl, 1'b1);

        drive(1'b0, 1'b0);
        cyc(10);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
